// File: rtl/lfsr_rng_ctrl.sv
// Two-requester arbiter around a Fibonacci LFSR.
// Each grant returns the LFSR word after STEPS shifts.
module lfsr_rng_ctrl #(
    parameter int unsigned      WIDTH = 3,
    parameter logic [WIDTH-1:0] TAPS  = 3'b101,
    parameter logic [WIDTH-1:0] SEED  = 3'b001,
    parameter int unsigned      STEPS = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             seed_we,
    input  logic [WIDTH-1:0] seed_in,
    input  logic [1:0]       req,
    output logic [1:0]       gnt,
    output logic [WIDTH-1:0] rnd_out,
    output logic             busy,
    output logic             seed_err
);

    localparam int unsigned CW = $clog2(STEPS + 1);
    localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] STEP  = 2'd1;
    localparam logic [1:0] GRANT = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] lfsr_q, lfsr_d;
    logic [WIDTH-1:0] rnd_q, rnd_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             sel_q, sel_d;
    logic             rr_last_q, rr_last_d;
    logic             seed_err_q, seed_err_d;

    logic             fb;
    logic [WIDTH-1:0] shifted;
    logic             win;

    // Next LFSR value and round-robin winner.
    always_comb begin
        fb      = ^(lfsr_q & TAPS);
        shifted = {lfsr_q[WIDTH-2:0], fb};
        if (req == 2'b11) win = ~rr_last_q;
        else              win = req[1];
    end

    // FSM next-state: seed loading, arbitration, stepping and grant.
    always_comb begin
        state_d    = state_q;
        lfsr_d     = lfsr_q;
        rnd_d      = rnd_q;
        cnt_d      = cnt_q;
        sel_d      = sel_q;
        rr_last_d  = rr_last_q;
        seed_err_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (seed_we) begin
                    if (seed_in != '0) begin
                        lfsr_d = seed_in;
                    end else begin
                        lfsr_d     = SEED;
                        seed_err_d = 1'b1;
                    end
                end else if (|req) begin
                    sel_d   = win;
                    cnt_d   = '0;
                    state_d = STEP;
                end
            end
            STEP: begin
                seed_err_d = seed_we;
                lfsr_d     = shifted;
                cnt_d      = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    state_d   = GRANT;
                    rnd_d     = shifted;
                    rr_last_d = sel_q;
                end
            end
            GRANT: begin
                seed_err_d = seed_we;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            lfsr_q     <= SEED;
            rnd_q      <= '0;
            cnt_q      <= '0;
            sel_q      <= 1'b0;
            rr_last_q  <= 1'b1;
            seed_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            lfsr_q     <= lfsr_d;
            rnd_q      <= rnd_d;
            cnt_q      <= cnt_d;
            sel_q      <= sel_d;
            rr_last_q  <= rr_last_d;
            seed_err_q <= seed_err_d;
        end
    end

    // Outputs decoded from registered state.
    always_comb begin
        gnt      = (state_q == GRANT) ? {sel_q, ~sel_q} : 2'b00;
        busy     = (state_q != IDLE);
        rnd_out  = rnd_q;
        seed_err = seed_err_q;
    end

endmodule

// File: tb/tb_lfsr_rng_ctrl.sv
// Directed bench for lfsr_rng_ctrl with default parameters.
// Expected words are hand-derived from the x^3 LFSR sequence.
module tb_lfsr_rng_ctrl;

    logic       clk;
    logic       rst_n;
    logic       seed_we;
    logic [2:0] seed_in;
    logic [1:0] req;
    logic [1:0] gnt;
    logic [2:0] rnd_out;
    logic       busy;
    logic       seed_err;

    int checks = 0;
    int errors = 0;

    lfsr_rng_ctrl dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .seed_we  (seed_we),
        .seed_in  (seed_in),
        .req      (req),
        .gnt      (gnt),
        .rnd_out  (rnd_out),
        .busy     (busy),
        .seed_err (seed_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Check that a grant never shows both bits.
    always @(negedge clk) begin
        if (rst_n) begin
            checks++;
            assert (gnt !== 2'b11) else begin
                errors++;
                $error("FAIL gnt_onehot: observed %b expected not 11", gnt);
            end
        end
    end

    task automatic check(input string tag, input logic [7:0] obs,
                         input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    // Tick until a grant appears or the budget runs out.
    task automatic wait_grant(input int maxc, output int n);
        n = 0;
        while (gnt == 2'b00 && n < maxc) begin
            tick();
            n++;
        end
    endtask

    logic [2:0] exp6 [0:7];
    int n;

    initial begin
        exp6[0] = 3'b110; exp6[1] = 3'b100;
        exp6[2] = 3'b111; exp6[3] = 3'b010;
        exp6[4] = 3'b011; exp6[5] = 3'b101;
        exp6[6] = 3'b001; exp6[7] = 3'b110;

        rst_n   = 1'b0;
        seed_we = 1'b0;
        seed_in = 3'b000;
        req     = 2'b00;
        tick();
        tick();
        check("rst_gnt", {6'd0, gnt}, 8'h0);
        check("rst_busy", {7'd0, busy}, 8'h0);
        check("rst_rnd", {5'd0, rnd_out}, 8'h0);
        check("rst_serr", {7'd0, seed_err}, 8'h0);
        rst_n = 1'b1;
        tick();

        // 1: single one-cycle request from requester 0
        req = 2'b01;
        tick();
        req = 2'b00;
        check("t1_busy1", {7'd0, busy}, 8'h1);
        check("t1_gnt1", {6'd0, gnt}, 8'h0);
        tick();
        check("t1_busy2", {7'd0, busy}, 8'h1);
        tick();
        check("t1_busy3", {7'd0, busy}, 8'h1);
        check("t1_gnt3", {6'd0, gnt}, 8'h0);
        tick();
        check("t1_gnt", {6'd0, gnt}, 8'h1);
        check("t1_busy4", {7'd0, busy}, 8'h1);
        check("t1_rnd", {5'd0, rnd_out}, 8'h6);
        tick();
        check("t1_gnt_off", {6'd0, gnt}, 8'h0);
        check("t1_idle", {7'd0, busy}, 8'h0);
        check("t1_rnd_hold", {5'd0, rnd_out}, 8'h6);

        // 2: both requesting, round-robin alternation
        do_reset();
        req = 2'b11;
        wait_grant(8, n);
        check("t2_lat", n[7:0], 8'd4);
        check("t2_g1", {6'd0, gnt}, 8'h1);
        check("t2_r1", {5'd0, rnd_out}, 8'h6);
        tick();
        wait_grant(8, n);
        check("t2_gap", n[7:0], 8'd4);
        check("t2_g2", {6'd0, gnt}, 8'h2);
        check("t2_r2", {5'd0, rnd_out}, 8'h4);
        tick();
        wait_grant(8, n);
        check("t2_g3", {6'd0, gnt}, 8'h1);
        check("t2_r3", {5'd0, rnd_out}, 8'h7);
        tick();
        wait_grant(8, n);
        check("t2_g4", {6'd0, gnt}, 8'h2);
        check("t2_r4", {5'd0, rnd_out}, 8'h2);
        req = 2'b00;
        tick();

        // 3: explicit seed then requester 1
        do_reset();
        seed_we = 1'b1;
        seed_in = 3'b101;
        tick();
        seed_we = 1'b0;
        check("t3_serr", {7'd0, seed_err}, 8'h0);
        check("t3_busy", {7'd0, busy}, 8'h0);
        req = 2'b10;
        wait_grant(8, n);
        req = 2'b00;
        check("t3_g", {6'd0, gnt}, 8'h2);
        check("t3_r", {5'd0, rnd_out}, 8'h1);
        tick();

        // 4: zero seed falls back, seed_we during STEP ignored
        do_reset();
        seed_we = 1'b1;
        seed_in = 3'b000;
        tick();
        seed_we = 1'b0;
        check("t4_serr", {7'd0, seed_err}, 8'h1);
        tick();
        check("t4_serr_end", {7'd0, seed_err}, 8'h0);
        req = 2'b01;
        wait_grant(8, n);
        req = 2'b00;
        check("t4_r_fallback", {5'd0, rnd_out}, 8'h6);
        tick();
        req = 2'b01;
        tick();
        req = 2'b00;
        seed_we = 1'b1;
        seed_in = 3'b101;
        tick();
        seed_we = 1'b0;
        check("t4_serr_step", {7'd0, seed_err}, 8'h1);
        wait_grant(8, n);
        check("t4_lat", n[7:0], 8'd2);
        check("t4_g", {6'd0, gnt}, 8'h1);
        check("t4_r", {5'd0, rnd_out}, 8'h4);
        tick();
        check("t4_serr_clr", {7'd0, seed_err}, 8'h0);

        // 5: reset mid-STEP, then dropped request
        req = 2'b01;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        check("t5_gnt", {6'd0, gnt}, 8'h0);
        check("t5_busy", {7'd0, busy}, 8'h0);
        check("t5_rnd", {5'd0, rnd_out}, 8'h0);
        check("t5_serr", {7'd0, seed_err}, 8'h0);
        rst_n = 1'b1;
        wait_grant(8, n);
        req = 2'b00;
        check("t5_lat", n[7:0], 8'd4);
        check("t5_r", {5'd0, rnd_out}, 8'h6);
        tick();
        req = 2'b01;
        tick();
        req = 2'b00;
        wait_grant(8, n);
        check("t5_drop_lat", n[7:0], 8'd3);
        check("t5_drop_g", {6'd0, gnt}, 8'h1);
        check("t5_drop_r", {5'd0, rnd_out}, 8'h4);
        tick();

        // 6: free run, period-7 word sequence
        do_reset();
        req = 2'b01;
        for (int i = 0; i < 8; i++) begin
            wait_grant(8, n);
            check($sformatf("t6_g%0d", i), {6'd0, gnt}, 8'h1);
            check($sformatf("t6_r%0d", i), {5'd0, rnd_out},
                  {5'd0, exp6[i]});
            tick();
        end
        req = 2'b00;
        tick();

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
